// File: rtl/core_types_pkg.sv
// Shared core-wide types and sizing constants for the fetch/predictor path.
package core_types_pkg;

    // Return address stack geometry. RAS_ENTRIES must be a power of two so
    // that pointer arithmetic can wrap by natural truncation.
    localparam int RAS_ENTRIES      = 8;
    localparam int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
    localparam int RAS_COUNT_WIDTH  = $clog2(RAS_ENTRIES + 1);
    localparam int RAS_TARGET_WIDTH = 31;

    typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;
    typedef logic [RAS_INDEX_WIDTH-1:0]  ras_index_t;
    typedef logic [RAS_COUNT_WIDTH-1:0]  ras_count_t;

    // The single state-changing action the stack performs in a cycle.
    typedef enum logic [2:0] {
        RAS_OP_HOLD,
        RAS_OP_PUSH,
        RAS_OP_POP,
        RAS_OP_REPLACE,
        RAS_OP_RESTORE
    } ras_op_e;

    // Resolve the request lines into one action. A backend restore wins over
    // anything fetch asks for in the same cycle.
    function automatic ras_op_e ras_decode(input logic update_valid,
                                           input logic link_valid,
                                           input logic ret_valid);
        ras_op_e op;
        if (update_valid)             op = RAS_OP_RESTORE;
        else if (link_valid && ret_valid) op = RAS_OP_REPLACE;
        else if (link_valid)          op = RAS_OP_PUSH;
        else if (ret_valid)           op = RAS_OP_POP;
        else                          op = RAS_OP_HOLD;
        return op;
    endfunction

endpackage : core_types_pkg

// File: rtl/ras.sv
// Return address stack: circular target array with a top pointer and an
// occupancy count, checkpointable by fetch and restorable by the backend.
module ras
    import core_types_pkg::*;
(
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        link_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] link_pc,
    input  logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_pc,
    output logic                        ret_hit,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
    input  logic                        update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
    input  logic [RAS_COUNT_WIDTH-1:0]  update_ras_count
);

    localparam ras_count_t COUNT_FULL = RAS_COUNT_WIDTH'(RAS_ENTRIES);
    localparam ras_count_t COUNT_ONE  = RAS_COUNT_WIDTH'(1);
    localparam ras_index_t INDEX_ONE  = RAS_INDEX_WIDTH'(1);

    ras_target_t stack_q [RAS_ENTRIES];
    ras_index_t  ptr_q;
    ras_count_t  count_q;

    ras_op_e     op;
    ras_index_t  ptr_d;
    ras_count_t  count_d;
    logic        wr_en;
    ras_index_t  wr_idx;

    // Decode this cycle's action and compute next pointer, count and write.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        op      = ras_decode(update_valid, link_valid, ret_valid);
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;

        unique case (op)
            RAS_OP_RESTORE: begin
                // Array contents are deliberately left as they are; entries
                // clobbered since the checkpoint stay wrong.
                ptr_d   = update_ras_index;
                count_d = (update_ras_count > COUNT_FULL) ? COUNT_FULL
                                                          : update_ras_count;
            end
            RAS_OP_PUSH: begin
                // When full, the write lands on the oldest entry and the
                // count simply stays saturated.
                ptr_d   = ptr_q + INDEX_ONE;
                wr_en   = 1'b1;
                wr_idx  = ptr_q + INDEX_ONE;
                count_d = (count_q == COUNT_FULL) ? COUNT_FULL
                                                  : count_q + COUNT_ONE;
            end
            RAS_OP_POP: begin
                // Popping an empty stack is a no-op; ret_pc stays a stale guess.
                if (count_q != '0) begin
                    ptr_d   = ptr_q - INDEX_ONE;
                    count_d = count_q - COUNT_ONE;
                end
            end
            RAS_OP_REPLACE: begin
                // Return followed by a call: the new link replaces the top.
                wr_en   = 1'b1;
                wr_idx  = ptr_q;
                count_d = (count_q == '0) ? COUNT_ONE : count_q;
            end
            RAS_OP_HOLD: begin
            end
            default: begin
            end
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!nRST) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Target storage; a single write port driven by push or replace.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: the array is reset on purpose so a stale pop right after reset
        // presents a defined zero target instead of X.
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= '0;
            end
        end else if (wr_en) begin
            stack_q[wr_idx] <= link_pc;
        end
    end

    // Outputs depend only on registered state.
    always_comb begin
        ret_pc    = stack_q[ptr_q];
        ret_hit   = (count_q != '0);
        ras_index = ptr_q;
        ras_count = count_q;
    end

endmodule : ras

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed scenarios plus random traffic compared
// against a behavioural stack model.
module tb_ras;
    import core_types_pkg::*;

    logic                        CLK;
    logic                        nRST;
    logic                        link_valid;
    logic [RAS_TARGET_WIDTH-1:0] link_pc;
    logic                        ret_valid;
    logic [RAS_TARGET_WIDTH-1:0] ret_pc;
    logic                        ret_hit;
    logic [RAS_INDEX_WIDTH-1:0]  ras_index;
    logic [RAS_COUNT_WIDTH-1:0]  ras_count;
    logic                        update_valid;
    logic [RAS_INDEX_WIDTH-1:0]  update_ras_index;
    logic [RAS_COUNT_WIDTH-1:0]  update_ras_count;

    int total = 0;
    int bad   = 0;

    // Reference model: plain array, integer top pointer and occupancy.
    logic [30:0] m_arr [8];
    int          m_ptr;
    int          m_cnt;
    int          hist_ptr [$];
    int          hist_cnt [$];

    ras dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .link_valid       (link_valid),
        .link_pc          (link_pc),
        .ret_valid        (ret_valid),
        .ret_pc           (ret_pc),
        .ret_hit          (ret_hit),
        .ras_index        (ras_index),
        .ras_count        (ras_count),
        .update_valid     (update_valid),
        .update_ras_index (update_ras_index),
        .update_ras_count (update_ras_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_arr[i] = '0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic model_apply(input logic lv, input logic [30:0] lp, input logic rv,
                               input logic uv, input int ui, input int uc);
        if (uv) begin
            m_ptr = ui;
            m_cnt = (uc > 8) ? 8 : uc;
        end else if (lv && rv) begin
            m_arr[m_ptr] = lp;
            if (m_cnt == 0) m_cnt = 1;
        end else if (lv) begin
            m_ptr = (m_ptr + 1) % 8;
            m_arr[m_ptr] = lp;
            if (m_cnt < 8) m_cnt++;
        end else if (rv) begin
            if (m_cnt != 0) begin
                m_ptr = (m_ptr + 7) % 8;
                m_cnt--;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ret_pc"},    {1'b0, ret_pc},   {1'b0, m_arr[m_ptr]});
        check({tag, ".ret_hit"},   32'(ret_hit),     32'(m_cnt != 0));
        check({tag, ".ras_index"}, 32'(ras_index),   32'(m_ptr));
        check({tag, ".ras_count"}, 32'(ras_count),   32'(m_cnt));
    endtask

    // One clock: drive requests, let the edge happen, update the model, compare.
    task automatic step(input logic lv, input logic [30:0] lp, input logic rv,
                        input logic uv = 1'b0, input int ui = 0, input int uc = 0);
        link_valid       = lv;
        link_pc          = lp;
        ret_valid        = rv;
        update_valid     = uv;
        update_ras_index = RAS_INDEX_WIDTH'(ui);
        update_ras_count = RAS_COUNT_WIDTH'(uc);
        @(posedge CLK);
        model_apply(lv, lp, rv, uv, ui, uc);
        #1;
        link_valid   = 1'b0;
        ret_valid    = 1'b0;
        update_valid = 1'b0;
        check_model("step");
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        nRST = 1'b0;
        #1;
        model_reset();
        check("rst.ret_pc", {1'b0, ret_pc}, 32'h0);
        check("rst.ret_hit", 32'(ret_hit), 32'h0);
        check("rst.ras_index", 32'(ras_index), 32'h0);
        check("rst.ras_count", 32'(ras_count), 32'h0);
        nRST = 1'b1;
    endtask

    initial begin
        int   rec_idx, rec_cnt, ui, uc, pick;
        logic lv, rv, uv;

        nRST             = 1'b0;
        link_valid       = 1'b0;
        link_pc          = '0;
        ret_valid        = 1'b0;
        update_valid     = 1'b0;
        update_ras_index = '0;
        update_ras_count = '0;
        model_reset();
        #12;
        nRST = 1'b1;

        // Idle after reset, then a pop on an empty stack.
        check_model("idle");
        check("idle.ret_hit", 32'(ret_hit), 32'h0);
        step(1'b0, '0, 1'b1);
        check("empty_pop.ras_index", 32'(ras_index), 32'h0);
        check("empty_pop.ras_count", 32'(ras_count), 32'h0);

        // Three pushes then three LIFO pops.
        step(1'b1, 31'h1000, 1'b0);
        step(1'b1, 31'h2000, 1'b0);
        step(1'b1, 31'h3000, 1'b0);
        check("p3.ras_index", 32'(ras_index), 32'd3);
        check("p3.ras_count", 32'(ras_count), 32'd3);
        check("p3.ret_pc", {1'b0, ret_pc}, 32'h3000);
        for (int k = 0; k < 3; k++) begin
            check("lifo.ret_pc", {1'b0, ret_pc}, 32'h3000 - 32'(k) * 32'h1000);
            step(1'b0, '0, 1'b1);
        end
        check("lifo.ras_count", 32'(ras_count), 32'd0);
        check("lifo.ret_hit", 32'(ret_hit), 32'd0);

        // Overflow: ten pushes saturate the count and wrap the pointer.
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b1, 31'h100 + 31'(k), 1'b0);
        check("ovf.ras_count", 32'(ras_count), 32'd8);
        check("ovf.ras_index", 32'(ras_index), 32'd2);
        for (int k = 0; k < 8; k++) begin
            check("ovf.ret_hit", 32'(ret_hit), 32'd1);
            check("ovf.ret_pc", {1'b0, ret_pc}, 32'h109 - 32'(k));
            step(1'b0, '0, 1'b1);
        end
        check("ovf.ret_hit_empty", 32'(ret_hit), 32'd0);

        // Replace on a one-deep stack, then on an empty stack.
        do_reset();
        step(1'b1, 31'h1111, 1'b0);
        step(1'b1, 31'h2222, 1'b1);
        check("repl.ras_index", 32'(ras_index), 32'd1);
        check("repl.ras_count", 32'(ras_count), 32'd1);
        check("repl.ret_pc", {1'b0, ret_pc}, 32'h2222);
        do_reset();
        step(1'b1, 31'h2222, 1'b1);
        check("repl_empty.ras_count", 32'(ras_count), 32'd1);
        check("repl_empty.ret_pc", {1'b0, ret_pc}, 32'h2222);

        // Checkpoint restore beats a simultaneous push.
        do_reset();
        for (int k = 1; k <= 5; k++) step(1'b1, 31'h5000 + 31'(k), 1'b0);
        rec_idx = int'(ras_index);
        rec_cnt = int'(ras_count);
        check("ckpt.ras_index", 32'(rec_idx), 32'd5);
        check("ckpt.ras_count", 32'(rec_cnt), 32'd5);
        step(1'b1, 31'h6006, 1'b0);
        step(1'b1, 31'h6007, 1'b0);
        step(1'b1, 31'h7777, 1'b0, 1'b1, 5, 5);
        check("restore.ras_index", 32'(ras_index), 32'd5);
        check("restore.ras_count", 32'(ras_count), 32'd5);
        check("restore.ret_pc", {1'b0, ret_pc}, 32'h5005);

        // Restore with an out-of-range count clamps to the stack depth.
        step(1'b0, '0, 1'b0, 1'b1, 3, 15);
        check("clamp.ras_count", 32'(ras_count), 32'd8);

        // Asynchronous reset with four entries held.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 31'h4400 + 31'(k), 1'b0);
        do_reset();

        // Random traffic; restores reuse earlier observed (ptr,count) pairs
        // or arbitrary values, including counts beyond the depth.
        for (int n = 0; n < 600; n++) begin
            hist_ptr.push_back(m_ptr);
            hist_cnt.push_back(m_cnt);
            if (hist_ptr.size() > 16) begin
                void'(hist_ptr.pop_front());
                void'(hist_cnt.pop_front());
            end
            lv = ($urandom_range(99) < 45);
            rv = ($urandom_range(99) < 40);
            uv = ($urandom_range(99) < 8);
            if ($urandom_range(3) == 0) begin
                ui = int'($urandom_range(7));
                uc = int'($urandom_range(15));
            end else begin
                pick = int'($urandom_range(hist_ptr.size() - 1));
                ui   = hist_ptr[pick];
                uc   = hist_cnt[pick];
            end
            step(lv, 31'($urandom), rv, uv, ui, uc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ras
